// File: rtl/i2s_tdm_clk_gen.sv
// Serial-audio clock generator on mclk: sclk, lrck/frame sync, mclk-domain edge strobes and
// slot/bit indices for I2S, left-justified and TDM (DSP-A) framing with frame-aligned start/stop.
//
// state   | meaning
// IDLE    | stopped, all outputs at reset values
// PREROLL | one pre-roll bit ahead of the first frame
// RUN     | framing; en only sampled at the last-bit point
// DRAIN   | final bit of the last frame; stop at its end
module i2s_tdm_clk_gen #(
    parameter int MCLK_DIV_SCLK = 4,
    parameter int SLOT_WIDTH    = 32,
    parameter int NUM_SLOTS     = 2,
    parameter int MODE          = 0,
    localparam int BW = $clog2(SLOT_WIDTH),
    localparam int SW = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic          mclk,
    input  logic          arst,
    input  logic          en,
    output logic          sclk,
    output logic          lrck,
    output logic          sclk_rise,
    output logic          sclk_fall,
    output logic [BW-1:0] bit_idx,
    output logic [SW-1:0] slot_idx,
    output logic          frame_start,
    output logic          busy
);

    localparam logic [10:0]   DIV_HALF   = 11'(MCLK_DIV_SCLK / 2 - 1);
    localparam logic [10:0]   DIV_LAST   = 11'(MCLK_DIV_SCLK - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(SLOT_WIDTH - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_SLOTS - 1);
    localparam logic [SW-1:0] SLOT_HALF  = SW'(NUM_SLOTS / 2);
    localparam logic          IDLE_LRCK  = (MODE == 0);
    localparam logic          PRE_LRCK   = (MODE == 2);

    typedef enum logic [1:0] {IDLE, PREROLL, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [10:0]   div_cnt, div_nx;
    logic          sclk_nx, rise_nx, fall_nx, fs_nx, busy_nx, lrck_nx;
    logic [BW-1:0] bit_nx, adv_bit;
    logic [SW-1:0] slot_nx, adv_slot, peek_slot;
    logic          bit_wrap, adv_first, adv_last, lrck_enter;

    // Position of the bit entered at the next sclk_fall, and the slot after that bit's slot
    assign bit_wrap  = (bit_idx == BIT_LAST);
    assign adv_bit   = bit_wrap ? '0 : bit_idx + BW'(1);
    assign adv_slot  = !bit_wrap ? slot_idx : ((slot_idx == SLOT_LAST) ? '0 : slot_idx + SW'(1));
    assign peek_slot = (adv_slot == SLOT_LAST) ? '0 : adv_slot + SW'(1);
    assign adv_first = (adv_bit == '0) && (adv_slot == '0);
    assign adv_last  = (adv_bit == BIT_LAST) && (adv_slot == SLOT_LAST);

    // I2S looks one bit ahead so lrck leads the slot boundary by one sclk
    always_comb begin
        if (MODE == 0)
            lrck_enter = (adv_bit == BIT_LAST) ? (peek_slot >= SLOT_HALF) : (adv_slot >= SLOT_HALF);
        else if (MODE == 1)
            lrck_enter = (adv_slot < SLOT_HALF);
        else
            lrck_enter = adv_last;
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        sclk_nx  = sclk;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        fs_nx    = 1'b0;
        busy_nx  = busy;
        bit_nx   = bit_idx;
        slot_nx  = slot_idx;
        lrck_nx  = lrck;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = PREROLL;
                    div_nx   = '0;
                    sclk_nx  = 1'b0;
                    fall_nx  = 1'b1;
                    busy_nx  = 1'b1;
                    bit_nx   = BIT_LAST;
                    slot_nx  = SLOT_LAST;
                    lrck_nx  = PRE_LRCK;
                end
            end
            default: begin
                div_nx = div_cnt + 11'd1;
                if (div_cnt == DIV_HALF) begin
                    sclk_nx = 1'b1;
                    rise_nx = 1'b1;
                end
                if (div_cnt == DIV_LAST) begin
                    div_nx  = '0;
                    sclk_nx = 1'b0;
                    if (state == DRAIN) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        bit_nx   = '0;
                        slot_nx  = '0;
                        lrck_nx  = IDLE_LRCK;
                    end else begin
                        fall_nx = 1'b1;
                        bit_nx  = adv_bit;
                        slot_nx = adv_slot;
                        fs_nx   = adv_first;
                        // Stopping holds lrck so the next frame's early event never shows
                        if (state == RUN && adv_last && !en)
                            state_nx = DRAIN;
                        else
                            lrck_nx = lrck_enter;
                        if (state == PREROLL && adv_first)
                            state_nx = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge mclk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            sclk        <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            bit_idx     <= '0;
            slot_idx    <= '0;
            lrck        <= IDLE_LRCK;
        end else begin
            state       <= state_nx;
            div_cnt     <= div_nx;
            sclk        <= sclk_nx;
            sclk_rise   <= rise_nx;
            sclk_fall   <= fall_nx;
            frame_start <= fs_nx;
            busy        <= busy_nx;
            bit_idx     <= bit_nx;
            slot_idx    <= slot_nx;
            lrck        <= lrck_nx;
        end
    end

endmodule

// File: tb/tb_i2s_tdm_clk_gen.sv
// Directed bench for i2s_tdm_clk_gen: I2S and left-justified defaults, an 8-slot TDM build,
// stop/restart sequencing and asynchronous reset.
module tb_i2s_tdm_clk_gen;

    logic mclk = 1'b0;
    logic arst = 1'b1;
    logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

    logic       sclk0, lrck0, rise0, fall0, fs0, busy0;
    logic [4:0] bit0;
    logic [0:0] slot0;
    logic       sclk1, lrck1, rise1, fall1, fs1, busy1;
    logic [4:0] bit1;
    logic [0:0] slot1;
    logic       sclk2, lrck2, rise2, fall2, fs2, busy2;
    logic [3:0] bit2;
    logic [2:0] slot2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 mclk = ~mclk;

    i2s_tdm_clk_gen #(.MCLK_DIV_SCLK(4), .SLOT_WIDTH(32), .NUM_SLOTS(2), .MODE(0)) d0 (
        .mclk(mclk), .arst(arst), .en(en0), .sclk(sclk0), .lrck(lrck0), .sclk_rise(rise0),
        .sclk_fall(fall0), .bit_idx(bit0), .slot_idx(slot0), .frame_start(fs0), .busy(busy0));

    i2s_tdm_clk_gen #(.MCLK_DIV_SCLK(4), .SLOT_WIDTH(32), .NUM_SLOTS(2), .MODE(1)) d1 (
        .mclk(mclk), .arst(arst), .en(en1), .sclk(sclk1), .lrck(lrck1), .sclk_rise(rise1),
        .sclk_fall(fall1), .bit_idx(bit1), .slot_idx(slot1), .frame_start(fs1), .busy(busy1));

    i2s_tdm_clk_gen #(.MCLK_DIV_SCLK(2), .SLOT_WIDTH(16), .NUM_SLOTS(8), .MODE(2)) d2 (
        .mclk(mclk), .arst(arst), .en(en2), .sclk(sclk2), .lrck(lrck2), .sclk_rise(rise2),
        .sclk_fall(fall2), .bit_idx(bit2), .slot_idx(slot2), .frame_start(fs2), .busy(busy2));

    // Expected {sclk,rise,fall,fs,busy,lrck,bit,slot} for DIV=4/32 bits/2 slots, t = cycles since pre-roll entry
    function automatic logic [11:0] exp_std(input int t, input bit lj);
        int p = t - 4;
        logic lr;
        logic [4:0] b;
        logic [0:0] s;
        if (lj) lr = (p >= 0) && ((p % 256) < 128);
        else    lr = (t % 256) >= 128;
        b = (p < 0) ? 5'd31 : 5'((p / 4) % 32);
        s = (p < 0) ? 1'b1  : 1'((p / 128) % 2);
        return {(t % 4) >= 2, (t % 4) == 2, (t % 4) == 0, (p >= 0) && ((p % 256) == 0), 1'b1, lr, b, s};
    endfunction

    task automatic restart(input int which);
        arst = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        repeat (2) @(negedge mclk);
        arst = 1'b0;
        if (which == 0) en0 = 1'b1;
        else if (which == 1) en1 = 1'b1;
        else en2 = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_reset();
        logic [11:0] a0, a1;
        logic [12:0] a2;
        @(negedge mclk);
        @(negedge mclk);
        a0 = {sclk0, rise0, fall0, fs0, busy0, lrck0, bit0, slot0};
        a1 = {sclk1, rise1, fall1, fs1, busy1, lrck1, bit1, slot1};
        a2 = {sclk2, rise2, fall2, fs2, busy2, lrck2, bit2, slot2};
        tests_run++;
        if (a0 !== {6'b000001, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_i2s: got %b want %b", a0, {6'b000001, 5'd0, 1'b0});
        end
        tests_run++;
        if (a1 !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_lj: got %b want %b", a1, 12'd0);
        end
        tests_run++;
        if (a2 !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_tdm: got %b want %b", a2, 13'd0);
        end
    endtask

    task automatic test_i2s_stream();
        int bad = 0, first_t = -1;
        logic [11:0] act, exp, fa = '0, fe = '0;
        restart(0);
        for (int t = 0; t < 600; t++) begin
            act = {sclk0, rise0, fall0, fs0, busy0, lrck0, bit0, slot0};
            exp = exp_std(t, 1'b0);
            if (act !== exp) begin
                bad++;
                if (first_t < 0) begin first_t = t; fa = act; fe = exp; end
            end
            @(negedge mclk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL i2s_stream: %0d wrong cycles, first t=%0d got %b want %b", bad, first_t, fa, fe);
        end
    endtask

    task automatic test_lj_stream();
        int bad = 0, first_t = -1;
        logic [11:0] act, exp, fa = '0, fe = '0;
        restart(1);
        for (int t = 0; t < 600; t++) begin
            act = {sclk1, rise1, fall1, fs1, busy1, lrck1, bit1, slot1};
            exp = exp_std(t, 1'b1);
            if (act !== exp) begin
                bad++;
                if (first_t < 0) begin first_t = t; fa = act; fe = exp; end
            end
            @(negedge mclk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL lj_stream: %0d wrong cycles, first t=%0d got %b want %b", bad, first_t, fa, fe);
        end
    endtask

    task automatic test_tdm_stream();
        int bad = 0, first_t = -1, p;
        logic [12:0] act, exp, fa = '0, fe = '0;
        logic [3:0] b;
        logic [2:0] s;
        restart(2);
        for (int t = 0; t < 600; t++) begin
            p = t - 2;
            b = (p < 0) ? 4'd15 : 4'((p / 2) % 16);
            s = (p < 0) ? 3'd7  : 3'((p / 32) % 8);
            exp = {(t % 2) == 1, (t % 2) == 1, (t % 2) == 0, (p >= 0) && ((p % 256) == 0),
                   1'b1, (t % 256) < 2, b, s};
            act = {sclk2, rise2, fall2, fs2, busy2, lrck2, bit2, slot2};
            if (act !== exp) begin
                bad++;
                if (first_t < 0) begin first_t = t; fa = act; fe = exp; end
            end
            @(negedge mclk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL tdm_stream: %0d wrong cycles, first t=%0d got %b want %b", bad, first_t, fa, fe);
        end
    endtask

    task automatic test_drop_mid();
        int fs_cnt = 0, late = 0;
        restart(0);
        for (int t = 0; t < 300; t++) begin
            if (fs0) fs_cnt++;
            if (t == 24) begin
                tests_run++;
                if ({bit0, slot0} !== {5'd5, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL drop_mid_point: bit/slot %0d/%0d want 5/0", bit0, slot0);
                end
                en0 = 1'b0;
            end
            if (t == 256) begin
                tests_run++;
                if ({fall0, busy0, lrck0} !== 3'b111) begin
                    tests_failed++;
                    $display("FAIL drop_mid_lastbit: fall/busy/lrck %b want 111", {fall0, busy0, lrck0});
                end
            end
            if (t == 259) begin
                tests_run++;
                if ({busy0, sclk0} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL drop_mid_drain: busy/sclk %b want 11", {busy0, sclk0});
                end
            end
            if (t == 260) begin
                tests_run++;
                if ({busy0, sclk0, fall0, fs0, lrck0, bit0, slot0} !== {5'b00001, 5'd0, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL drop_mid_idle: got %b want %b",
                             {busy0, sclk0, fall0, fs0, lrck0, bit0, slot0}, {5'b00001, 5'd0, 1'b0});
                end
            end
            if (t > 260 && (busy0 || sclk0 || fall0 || rise0 || !lrck0)) late++;
            @(negedge mclk);
        end
        tests_run++;
        if (fs_cnt != 1 || late != 0) begin
            tests_failed++;
            $display("FAIL drop_mid_after: frame_starts %0d want 1, activity after stop %0d want 0", fs_cnt, late);
        end
    endtask

    task automatic test_drop_last_restart();
        int fs_cnt = 0;
        restart(0);
        for (int t = 0; t < 300; t++) begin
            if (fs0) fs_cnt++;
            if (t == 256) begin
                tests_run++;
                if ({fall0, lrck0, bit0, slot0} !== {2'b11, 5'd31, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL restart_lastbit: got %b want %b", {fall0, lrck0, bit0, slot0}, {2'b11, 5'd31, 1'b1});
                end
            end
            if (t == 260) begin
                tests_run++;
                if ({busy0, sclk0, fall0, fs0} !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL restart_idle: busy/sclk/fall/fs %b want 0000", {busy0, sclk0, fall0, fs0});
                end
            end
            if (t == 261) begin
                tests_run++;
                if ({fall0, busy0, lrck0, bit0, slot0} !== {3'b110, 5'd31, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL restart_preroll: got %b want %b", {fall0, busy0, lrck0, bit0, slot0}, {3'b110, 5'd31, 1'b1});
                end
            end
            if (t == 265) begin
                tests_run++;
                if ({fs0, bit0, slot0} !== {1'b1, 5'd0, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL restart_frame: fs/bit/slot %b want %b", {fs0, bit0, slot0}, {1'b1, 5'd0, 1'b0});
                end
            end
            if (t == 255) en0 = 1'b0;
            if (t == 256) en0 = 1'b1;
            @(negedge mclk);
        end
        tests_run++;
        if (fs_cnt != 2) begin
            tests_failed++;
            $display("FAIL restart_count: frame_starts %0d want 2", fs_cnt);
        end
    endtask

    task automatic test_arst_mid();
        int early = 0;
        restart(0);
        repeat (50) @(negedge mclk);
        arst = 1'b1;
        #1;
        tests_run++;
        if ({sclk0, rise0, fall0, fs0, busy0, lrck0, bit0, slot0} !== {6'b000001, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL arst_immediate: got %b want %b",
                     {sclk0, rise0, fall0, fs0, busy0, lrck0, bit0, slot0}, {6'b000001, 5'd0, 1'b0});
        end
        @(negedge mclk);
        arst = 1'b0;
        @(negedge mclk);
        tests_run++;
        if ({sclk0, fall0, busy0, lrck0, bit0, slot0} !== {4'b0110, 5'd31, 1'b1}) begin
            tests_failed++;
            $display("FAIL arst_preroll: got %b want %b", {sclk0, fall0, busy0, lrck0, bit0, slot0}, {4'b0110, 5'd31, 1'b1});
        end
        for (int t = 1; t < 4; t++) begin
            @(negedge mclk);
            if (fs0 || fall0) early++;
        end
        @(negedge mclk);
        tests_run++;
        if (early != 0 || {fs0, fall0, bit0, slot0} !== {2'b11, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL arst_frame: early strobes %0d want 0, fs/fall/bit/slot %b want %b",
                     early, {fs0, fall0, bit0, slot0}, {2'b11, 5'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_i2s_stream();
        test_lj_stream();
        test_tdm_stream();
        test_drop_mid();
        test_drop_last_restart();
        test_arst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
